// File: rtl/pattern_gen_pkg.sv
// Shared types and constants for the pattern generator: mode and FSM encodings
// plus helpers that build the width-dependent SEED/POLY defaults.
package pattern_gen_pkg;

  localparam int unsigned MaxWidth = 128;

  localparam logic [2:0] ModeEncConst  = 3'd0;
  localparam logic [2:0] ModeEncToggle = 3'd1;
  localparam logic [2:0] ModeEncWalk1  = 3'd2;
  localparam logic [2:0] ModeEncCount  = 3'd3;
  localparam logic [2:0] ModeEncPrbs   = 3'd4;

  typedef enum logic [2:0] {
    ModeConst  = ModeEncConst,
    ModeToggle = ModeEncToggle,
    ModeWalk1  = ModeEncWalk1,
    ModeCount  = ModeEncCount,
    ModePrbs   = ModeEncPrbs
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Unassigned encodings 5..7 fall back to CONST.
  function automatic mode_e decode_mode(logic [2:0] m);
    case (m)
      ModeEncToggle: return ModeToggle;
      ModeEncWalk1:  return ModeWalk1;
      ModeEncCount:  return ModeCount;
      ModeEncPrbs:   return ModePrbs;
      default:       return ModeConst;
    endcase
  endfunction

  // Top w bits of 1010...10, so the MSB is always 1.
  function automatic logic [MaxWidth-1:0] default_seed(int unsigned w);
    logic [MaxWidth-1:0] pat;
    pat = {(MaxWidth / 2){2'b10}};
    return pat >> (MaxWidth - w);
  endfunction

  // 64'hD800_0000_0000_0000 left-aligned, keeping its w most-significant bits.
  function automatic logic [MaxWidth-1:0] default_poly(int unsigned w);
    logic [MaxWidth-1:0] pat;
    pat = {64'hD800_0000_0000_0000, 64'h0};
    return pat >> (MaxWidth - w);
  endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// One Galois LFSR step: shift right, fold in the tap mask when a 1 falls out.
module pattern_lfsr
  import pattern_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = 64,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH))
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur >> 1;
    if (cur[0]) begin
      nxt = nxt ^ POLY;
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Burst pattern generator: emits CONST/TOGGLE/WALK1/COUNT/PRBS words on a
// valid/ready stream, bounded by a beat count or open-ended until abort.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = 64,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(default_seed(WIDTH)),
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
  parameter int unsigned      LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       mode,
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done,
  output logic             busy
);

  if (WIDTH < 8 || WIDTH > MaxWidth) begin : g_width_check
    $error("pattern_gen: WIDTH out of range 8..128");
  end

  // An all-zero LFSR state would lock up, so PRBS starts from 1 in that case.
  localparam logic [WIDTH-1:0] PrbsSeed  = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [WIDTH-1:0] Walk1Seed = WIDTH'(1);

  state_e           state_q;
  mode_e            mode_q;
  // Beats left in a bounded burst; stays 0 for an unbounded one.
  logic [LEN_W-1:0] remain_q;

  mode_e            start_mode;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] prbs_next;

  pattern_lfsr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_lfsr (
    .cur (out_data),
    .nxt (prbs_next)
  );

  assign start_mode = decode_mode(mode);

  always_comb begin
    first_word = SEED;
    case (start_mode)
      ModeWalk1: first_word = Walk1Seed;
      ModePrbs:  first_word = PrbsSeed;
      default:   first_word = SEED;
    endcase
  end

  always_comb begin
    next_word = out_data;
    case (mode_q)
      ModeToggle: next_word = ~out_data;
      ModeWalk1:  next_word = {out_data[WIDTH-2:0], out_data[WIDTH-1]};
      ModeCount:  next_word = out_data + WIDTH'(1);
      ModePrbs:   next_word = prbs_next;
      default:    next_word = out_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= ModeConst;
      remain_q  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StRun;
            mode_q    <= start_mode;
            remain_q  <= len;
            out_data  <= first_word;
            out_valid <= 1'b1;
            out_last  <= (len == LEN_W'(1));
            busy      <= 1'b1;
          end
        end
        StRun: begin
          // out_valid is high for the whole of RUN, so out_ready alone marks a transfer.
          if (abort) begin
            state_q   <= StDone;
            remain_q  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
          end else if (out_ready) begin
            if (out_last) begin
              state_q   <= StDone;
              remain_q  <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_data <= next_word;
              if (remain_q != '0) begin
                remain_q <= remain_q - LEN_W'(1);
                out_last <= (remain_q == LEN_W'(2));
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
